hub75_scan_ctrl: RTL
====================

Name: hub75_scan_ctrl

Overview:
Scan sequencer for the HUB75 LED panel driver. It reads two pixels per column (top and bottom half) from the framebuffer, shifts them out one binary-coded-modulation (BCM) bit plane at a time, then latches the data, selects the row and opens the output-enable window for a plane-weighted time. It replaces the ad-hoc column/row accumulator plus frequency-divider chain with a single FSM that owns o_clk, o_latch, o_blank, RGB data and row select.

Parameters:
COLS, 64, columns per row (shift length); >=2
ROW_BITS, 5, row-select width; half-panel rows = 2**ROW_BITS
BITS, 4, colour bits per channel (BCM planes); 1..8
DIV, 2, shift-clock half period in i_clk cycles; >=2
BASE, 8, display cycles for plane 0; plane p displays BASE<<p cycles

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset, sampled on rising edge of i_clk
i_enable  in  1  start and keep scanning frames
o_rd_en  out  1  framebuffer read strobe, 1-cycle pulse
o_rd_col  out  clog2(COLS)  read column address
o_rd_row  out  ROW_BITS  read row address (top half; bottom half = same row + 2**ROW_BITS, handled by the framebuffer)
i_px_top  in  3*BITS  top pixel {r,g,b}, valid 1 cycle after o_rd_en
i_px_bot  in  3*BITS  bottom pixel, same format and timing
o_clk  out  1  panel shift clock
o_latch  out  1  panel latch
o_blank  out  1  panel output disable (1 = dark)
o_data_r  out  2  [0] = top bit, [1] = bottom bit
o_data_g  out  2  same
o_data_b  out  2  same
o_row_select  out  ROW_BITS  panel row address
o_frame_done  out  1  1-cycle pulse at end of each frame

Behaviour:
- Reset (i_rst_n=0 on a clock edge): state IDLE; o_clk=0, o_latch=0, o_blank=1, data=0, o_row_select=0, o_rd_en=0, o_frame_done=0; row, plane and column counters=0. Reset mid-frame aborts immediately and applies on the same edge.
- All outputs are registered.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: o_blank=1. If i_enable=1, go to SHIFT next cycle with row=0, plane=0, col=0.
- SHIFT: phase counter ph runs 0..2*DIV-1 per column.
  - ph=0: o_rd_en=1, o_rd_col=col, o_rd_row=row.
  - ph=1: o_data_* load bit [plane] of each channel (top -> [0], bottom -> [1]).
  - o_clk=0 for ph<DIV and 1 for ph>=DIV, so data is stable for >=1 cycle before the rising edge.
  - After ph=2*DIV-1 of col=COLS-1, go to BLANK; otherwise col+1, ph=0.
  - o_blank=1 throughout SHIFT.
- BLANK: 1 cycle; o_clk=0, o_blank=1.
- LATCH: 1 cycle; o_latch=1, o_row_select<=row (the row change happens while the panel is dark).
- DISPLAY: o_blank=0 for exactly BASE<<plane cycles; o_latch=0; data held.
- Leaving DISPLAY:
  - plane+1, or if plane=BITS-1: plane=0 and row+1.
  - If row wraps from 2**ROW_BITS-1: pulse o_frame_done for 1 cycle (the cycle after the last DISPLAY cycle).
  - Then SHIFT if i_enable=1, else IDLE (o_blank=1).
  - i_enable is sampled only at frame boundaries and in IDLE; deasserting it mid-frame completes the current frame.
- Slot length = COLS*2*DIV + 2 + (BASE<<plane) cycles.
- Frame length = 2**ROW_BITS * sum over planes of slot length.
- Counters are sized by clog2 with no overflow; the DISPLAY counter width must hold BASE<<(BITS-1).

Optional Feature:
HUB75_BRIGHTNESS_EN
- Defined: adds input i_brightness [7:0], sampled at each LATCH. During DISPLAY, o_blank=0 only for the first ((BASE<<plane)*i_brightness)>>8 cycles and 1 for the rest; DISPLAY length is unchanged. i_brightness=0 gives a dark panel with normal timing.
- Undefined: the port is absent and on-time is the full BASE<<plane cycles.

Test Plan:
(All tests use COLS=4, ROW_BITS=1, BITS=2, DIV=2, BASE=4.)
1. Reset hold, i_enable=1 -> all outputs at reset values; no o_rd_en while i_rst_n=0.
2. Enable from IDLE, framebuffer returns top r=2'b01, bottom b=2'b10 -> plane 0 shift: o_data_r=2'b01, o_data_b=2'b00; plane 1: o_data_r=2'b00, o_data_b=2'b10; 4 rising o_clk edges per slot; o_rd_col sequence 0,1,2,3.
3. Timing -> plane-0 slot = 22 cycles with o_blank=0 for 4; plane-1 slot = 26 with o_blank=0 for 8; o_frame_done pulse every 96 cycles; o_row_select 0 then 1, changing only in LATCH.
4. Deassert i_enable during row 0 -> frame completes, o_frame_done pulses, then IDLE with o_blank=1 and no further o_rd_en.
5. Assert i_rst_n=0 during DISPLAY -> next edge o_blank=1, o_row_select=0; on release with i_enable=1, restarts at row 0, plane 0.
6. HUB75_BRIGHTNESS_EN, i_brightness=128 -> o_blank=0 for 2 cycles (plane 0) and 4 cycles (plane 1); slot lengths still 22 and 26.

Source files
------------

// File: rtl/hub75_scan_ctrl_if.sv
// Framebuffer read bus between the HUB75 scan controller (master) and the
// framebuffer (slave).
//   o_rd_en   : 1-cycle read strobe
//   o_rd_col  : column address
//   o_rd_row  : row address (top half; framebuffer adds the bottom-half offset)
//   i_px_top  : top pixel {r,g,b}, valid the cycle after o_rd_en
//   i_px_bot  : bottom pixel, same format and timing
interface hub75_scan_ctrl_if #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int BITS     = 4
);
  logic                    o_rd_en;
  logic [$clog2(COLS)-1:0] o_rd_col;
  logic [ROW_BITS-1:0]     o_rd_row;
  logic [3*BITS-1:0]       i_px_top;
  logic [3*BITS-1:0]       i_px_bot;

  modport master (
    output o_rd_en, o_rd_col, o_rd_row,
    input  i_px_top, i_px_bot
  );

  modport slave (
    input  o_rd_en, o_rd_col, o_rd_row,
    output i_px_top, i_px_bot
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: fetches top/bottom pixels per column, shifts one BCM
// bit plane out, latches it, switches the row while dark, then opens the
// output-enable window for BASE<<plane cycles.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_enable            : scan frames; sampled in IDLE and at frame boundaries
//   i_brightness        : on-time scale (x/256), present only when
//                         HUB75_BRIGHTNESS_EN is defined
//   fb                  : framebuffer read bus (master modport)
//   o_clk, o_latch      : panel shift clock and latch
//   o_blank             : panel output disable (1 = dark)
//   o_data_r/g/b        : [0] top bit, [1] bottom bit of the current plane
//   o_row_select        : panel row address
//   o_frame_done        : 1-cycle pulse after the last slot of a frame
// Optional feature macro: HUB75_BRIGHTNESS_EN
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | panel dark, waiting for i_enable
// S_SHIFT   | fetch and shift COLS columns of the current plane
// S_BLANK   | one dark cycle with o_clk low before latching
// S_LATCH   | latch pulse, row select updated while dark
// S_DISPLAY | output enabled for the plane-weighted time
module hub75_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int BITS     = 4,
  parameter int DIV      = 2,
  parameter int BASE     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]          i_brightness,
`endif
  hub75_scan_ctrl_if.master   fb,
  output logic                o_clk,
  output logic                o_latch,
  output logic                o_blank,
  output logic [1:0]          o_data_r,
  output logic [1:0]          o_data_g,
  output logic [1:0]          o_data_b,
  output logic [ROW_BITS-1:0] o_row_select,
  output logic                o_frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PH_W   = $clog2(2 * DIV);
  localparam int PL_W   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DISP_W = $clog2((BASE << (BITS - 1)) + 1);

  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
  localparam logic [PH_W-1:0]     PH_LOAD  = PH_W'(1);
  localparam logic [PH_W-1:0]     PH_HI    = PH_W'(DIV);
  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(2 * DIV - 1);
  localparam logic [PL_W-1:0]     PL_LAST  = PL_W'(BITS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
  localparam logic [DISP_W-1:0]   BASE_V   = DISP_W'(BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
  } state_t;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [PH_W-1:0]     ph;
  logic [PL_W-1:0]     plane;
  logic [ROW_BITS-1:0] row;
  logic [DISP_W-1:0]   disp_cnt;
  logic [DISP_W-1:0]   on_left;

  logic [DISP_W-1:0]   disp_len;
  logic [DISP_W-1:0]   on_len;
  logic                plane_last;
  logic                frame_last;
  logic [PL_W-1:0]     plane_nxt;
  logic [ROW_BITS-1:0] row_nxt;

  always_comb begin
    disp_len   = BASE_V << plane;
    plane_last = (plane == PL_LAST);
    frame_last = plane_last && (row == ROW_LAST);
    plane_nxt  = plane_last ? '0 : plane + 1'b1;
    row_nxt    = plane_last ? row + 1'b1 : row;
  end

`ifdef HUB75_BRIGHTNESS_EN
  logic [DISP_W+7:0] on_prod;
  assign on_prod = {8'd0, disp_len} * {{DISP_W{1'b0}}, i_brightness};
  assign on_len  = on_prod[DISP_W+7:8];
`else
  assign on_len = disp_len;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      col          <= '0;
      ph           <= '0;
      plane        <= '0;
      row          <= '0;
      disp_cnt     <= '0;
      on_left      <= '0;
      o_clk        <= 1'b0;
      o_latch      <= 1'b0;
      o_blank      <= 1'b1;
      o_data_r     <= '0;
      o_data_g     <= '0;
      o_data_b     <= '0;
      o_row_select <= '0;
      o_frame_done <= 1'b0;
      fb.o_rd_en   <= 1'b0;
      fb.o_rd_col  <= '0;
      fb.o_rd_row  <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_latch      <= 1'b0;
      fb.o_rd_en   <= 1'b0;
      case (state)
        S_IDLE: begin
          o_blank <= 1'b1;
          o_clk   <= 1'b0;
          if (i_enable) begin
            state       <= S_SHIFT;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            ph          <= '0;
            fb.o_rd_en  <= 1'b1;
            fb.o_rd_col <= '0;
            fb.o_rd_row <= '0;
          end
        end
        S_SHIFT: begin
          // o_clk follows ph one cycle late so the rising edge lands a full
          // cycle after the data register changes (data loads on the ph=1 edge).
          o_clk <= (ph >= PH_HI);
          if (ph == PH_LOAD) begin
            o_data_r <= {fb.i_px_bot[2*BITS + plane], fb.i_px_top[2*BITS + plane]};
            o_data_g <= {fb.i_px_bot[BITS + plane],   fb.i_px_top[BITS + plane]};
            o_data_b <= {fb.i_px_bot[plane],          fb.i_px_top[plane]};
          end
          if (ph == PH_LAST) begin
            ph <= '0;
            if (col == COL_LAST) begin
              state <= S_BLANK;
              o_clk <= 1'b0;
            end else begin
              col         <= col + 1'b1;
              fb.o_rd_en  <= 1'b1;
              fb.o_rd_col <= col + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_BLANK: begin
          state        <= S_LATCH;
          o_clk        <= 1'b0;
          o_latch      <= 1'b1;
          o_row_select <= row;
        end
        S_LATCH: begin
          state    <= S_DISPLAY;
          disp_cnt <= disp_len - 1'b1;
          on_left  <= on_len;
          o_blank  <= (on_len == '0);
        end
        S_DISPLAY: begin
          // on_left counts the remaining lit cycles including the current one.
          if (on_left != '0) on_left <= on_left - 1'b1;
          o_blank <= (on_left[DISP_W-1:1] == '0);
          if (disp_cnt == '0) begin
            o_blank <= 1'b1;
            plane   <= plane_nxt;
            row     <= row_nxt;
            col     <= '0;
            ph      <= '0;
            if (frame_last) o_frame_done <= 1'b1;
            if (!frame_last || i_enable) begin
              state       <= S_SHIFT;
              fb.o_rd_en  <= 1'b1;
              fb.o_rd_col <= '0;
              fb.o_rd_row <= row_nxt;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            disp_cnt <= disp_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
